// File: rtl/msg_sched_pkg.sv
// Shared types and constants for the message scheduler.
package msg_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SEND,
    S_WAIT_TX,
    S_GAP
  } state_t;

  localparam logic [7:0] END_CHAR_DEF = 8'h23;

  // Requester slots; REQ_END outranks the three formatters.
  localparam logic [1:0] REQ_FAULT   = 2'd0;
  localparam logic [1:0] REQ_PICKUP  = 2'd1;
  localparam logic [1:0] REQ_DEPOSIT = 2'd2;
  localparam logic [1:0] REQ_END     = 2'd3;

  // Round-robin slot p+k over the three formatter slots (0..2).
  function automatic logic [1:0] rr_add(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

endpackage

// File: rtl/msg_rr_arbiter.sv
// Strict priority for the end-run requester, round-robin over the rest.
module msg_rr_arbiter
  import msg_sched_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

  // Pick req[3] if set, else first requester at or after ptr (wrapping 2->0).
  always_comb begin
    grant = '0;
    if (req[REQ_END]) begin
      grant[REQ_END] = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (grant == 4'd0 && req[rr_add(ptr, k)]) grant[rr_add(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_scheduler.sv
// Frames bytes from one of four requesters onto a shared UART, then enforces
// an idle gap before the next frame.
module msg_scheduler
  import msg_sched_pkg::*;
#(
  parameter int         TIMEOUT    = 50000,
  parameter int         GAP_CYCLES = 4340,
  parameter int         MAX_LEN    = 16,
  parameter logic [7:0] END_CHAR   = END_CHAR_DEF
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  byte_valid,
  input  logic [31:0] byte_data,
  output logic [3:0]  byte_ready,
  output logic [3:0]  gnt,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  active_id
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state, state_nx;
  logic [1:0]    rr_ptr;
  logic [4:0]    byte_cnt;
  logic [15:0]   to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          first_tx;
  logic [3:0]    arb_gnt;
  logic [1:0]    arb_id;
  logic          timeout_hit, tx_idle, last_end, len_hit, to_gap;

  msg_rr_arbiter u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  // One-hot arbiter grant to requester index.
  always_comb begin
    case (arb_gnt)
      4'b0001: arb_id = REQ_FAULT;
      4'b0010: arb_id = REQ_PICKUP;
      4'b0100: arb_id = REQ_DEPOSIT;
      default: arb_id = REQ_END;
    endcase
  end

  assign timeout_hit = (to_cnt == 16'(TIMEOUT));
  // UART busy is not yet visible in the first WAIT_TX cycle.
  assign tx_idle     = !first_tx && !tx_busy;
  assign last_end    = (tx_data == END_CHAR);
  assign len_hit     = (byte_cnt == 5'(MAX_LEN - 1));
  assign to_gap      = (state != S_GAP) && (state_nx == S_GAP);

  // State register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx   = state;
    byte_ready = '0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      S_IDLE: if (|req) state_nx = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (timeout_hit) begin
          frame_err = 1'b1;
          state_nx  = S_GAP;
        end else begin
          byte_ready[active_id] = !tx_busy;
          if (byte_valid[active_id] && !tx_busy) state_nx = S_SEND;
        end
      end
      S_SEND: begin
        tx_start = 1'b1;
        state_nx = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_idle) begin
          if (last_end) begin
            frame_done = 1'b1;
            state_nx   = S_GAP;
          end else if (len_hit) begin
            frame_err = 1'b1;
            state_nx  = S_GAP;
          end else begin
            state_nx = S_WAIT_BYTE;
          end
        end
      end
      S_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Grant, byte latch, counters and round-robin pointer.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      active_id <= '0;
      tx_data   <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      first_tx  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt       <= arb_gnt;
            active_id <= arb_id;
            byte_cnt  <= '0;
            to_cnt    <= '0;
          end
        end
        S_WAIT_BYTE: begin
          if (state_nx == S_SEND) tx_data <= byte_data[{active_id, 3'b000} +: 8];
          else                    to_cnt  <= to_cnt + 16'd1;
        end
        S_SEND: first_tx <= 1'b1;
        S_WAIT_TX: begin
          first_tx <= 1'b0;
          if (state_nx == S_WAIT_BYTE) begin
            byte_cnt <= byte_cnt + 5'd1;
            to_cnt   <= '0;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
      // Frame end (done or error): drop grant, start gap, advance pointer
      // past a formatter; end-run frames leave the pointer alone.
      if (to_gap) begin
        gnt     <= '0;
        gap_cnt <= '0;
        if (active_id != REQ_END) rr_ptr <= rr_add(active_id, 1);
      end
    end
  end

endmodule

// File: tb/tb_msg_scheduler.sv
// Directed bench for msg_scheduler: frame table plus priority-wait and
// mid-frame reset sequences, with a requester/UART behavioural model.
module tb_msg_scheduler;

  localparam int TB_TIMEOUT = 20;
  localparam int TB_GAP     = 8;
  localparam int TB_MAXLEN  = 16;
  localparam int BUSY       = 10;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  byte_valid;
  logic [31:0] byte_data;
  logic [3:0]  byte_ready;
  logic [3:0]  gnt;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  active_id;

  msg_scheduler #(
    .TIMEOUT    (TB_TIMEOUT),
    .GAP_CYCLES (TB_GAP),
    .MAX_LEN    (TB_MAXLEN),
    .END_CHAR   (8'h23)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .req        (req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .gnt        (gnt),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .active_id  (active_id)
  );

  always #10 clk_50M = ~clk_50M;

  int n_chk  = 0;
  int n_fail = 0;

  // Shared message buffer: every requester streams the same message.
  logic [7:0] mbuf [32];
  int         mlen = 0;
  int         frame_seq = 0;
  logic [7:0] txq [$];
  int         viol = 0;

  typedef struct {
    logic [3:0] req;
    int         msg;
    logic [3:0] gnt;
    logic [1:0] id;
    bit         done;
    int         nbytes;
  } vec_t;

  vec_t tv [9];

  function automatic string msg_of(input int k);
    case (k)
      0:       return "A#";
      1:       return "B#";
      2:       return "C#";
      3:       return "D#";
      4:       return "";
      5:       return "BPM-SU-B2-#";
      6:       return "ABCDEFGHIJKLMNOPQ";
      7:       return "E#";
      8:       return "ABCDEFGHIJKLMNO#";
      9:       return "FG#";
      default: return "XYZW#";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_msg(input int k);
    string s;
    s = msg_of(k);
    mlen = s.len();
    for (int i = 0; i < mlen; i++) mbuf[i] = s[i];
    frame_seq++;
  endtask

  task automatic tick();
    @(negedge clk_50M);
    #2;
  endtask

  task automatic wait_gnt(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (gnt != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_end(input string name, output bit done, output int cyc);
    bit ok;
    ok = 1'b0;
    done = 1'b0;
    cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      cyc++;
      if (frame_done || frame_err) begin
        done = frame_done;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_end_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_txq(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("txq_wait_timeout", 32'd0, 32'd1);
  endtask

  // Requester and UART model, driven on the falling edge.
  initial begin : model
    int         busy_cnt;
    int         seen_seq;
    int         idx [4];
    logic [3:0] pend;
    busy_cnt   = 0;
    seen_seq   = 0;
    pend       = '0;
    tx_busy    = 1'b0;
    byte_valid = '0;
    byte_data  = '0;
    for (int i = 0; i < 4; i++) idx[i] = 0;
    forever begin
      @(negedge clk_50M);
      if (seen_seq != frame_seq) begin
        seen_seq = frame_seq;
        for (int i = 0; i < 4; i++) idx[i] = 0;
        pend = '0;
        txq.delete();
      end
      if (!rst_n) begin
        busy_cnt = 0;
        pend = '0;
      end else begin
        if (tx_start) begin
          txq.push_back(tx_data);
          busy_cnt = BUSY;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
      end
      tx_busy = (busy_cnt > 0);
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) idx[i]++;
        byte_valid[i] = (idx[i] < mlen);
        byte_data[8*i +: 8] = (idx[i] < mlen) ? mbuf[idx[i]] : 8'h00;
      end
      #1;
      pend = byte_ready & byte_valid;
      if (gnt == 4'd0 && (byte_ready != 4'd0 || tx_start || frame_done || frame_err)) viol++;
    end
  end

  initial begin : main
    bit done;
    int cyc;
    int nbad;
    int gap;

    tv[0] = '{4'b0011, 0, 4'b0001, 2'd0, 1'b1, 2};
    tv[1] = '{4'b0011, 1, 4'b0010, 2'd1, 1'b1, 2};
    tv[2] = '{4'b1111, 2, 4'b1000, 2'd3, 1'b1, 2};
    tv[3] = '{4'b0111, 3, 4'b0100, 2'd2, 1'b1, 2};
    tv[4] = '{4'b0111, 4, 4'b0001, 2'd0, 1'b0, 0};
    tv[5] = '{4'b0111, 5, 4'b0010, 2'd1, 1'b1, 11};
    tv[6] = '{4'b0101, 6, 4'b0100, 2'd2, 1'b0, 16};
    tv[7] = '{4'b0100, 7, 4'b0100, 2'd2, 1'b1, 2};
    tv[8] = '{4'b0110, 8, 4'b0010, 2'd1, 1'b1, 16};

    rst_n = 1'b0;
    req   = 4'd0;
    #25;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_strobes", 32'({byte_ready, tx_start, frame_done, frame_err}), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Frame table.
    for (int v = 0; v < 9; v++) begin
      load_msg(tv[v].msg);
      req = tv[v].req;
      wait_gnt($sformatf("v%0d", v));
      chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(tv[v].gnt));
      chk($sformatf("v%0d_id", v), 32'(active_id), 32'(tv[v].id));
      wait_end($sformatf("v%0d", v), done, cyc);
      chk($sformatf("v%0d_done", v), 32'(done), 32'(tv[v].done));
      chk($sformatf("v%0d_nbytes", v), 32'(txq.size()), 32'(tv[v].nbytes));
      nbad = 0;
      for (int j = 0; j < txq.size() && j < 32; j++) if (txq[j] !== mbuf[j]) nbad++;
      chk($sformatf("v%0d_bytes_bad", v), 32'(nbad), 32'd0);
      if (tv[v].nbytes == 0 && !tv[v].done)
        chk($sformatf("v%0d_timeout_cyc", v), 32'(cyc), 32'(TB_TIMEOUT));
    end

    // End-run request arriving mid-frame waits, then wins after the gap.
    load_msg(9);
    req = 4'b0011;
    wait_gnt("pri");
    chk("pri_gnt0", 32'(gnt), 32'b0001);
    wait_txq(1);
    req = 4'b1011;
    chk("pri_hold_gnt", 32'(gnt), 32'b0001);
    wait_end("pri0", done, cyc);
    chk("pri_done0", 32'(done), 32'd1);
    chk("pri_bytes0", 32'(txq.size()), 32'd3);
    gap = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (gnt == 4'd0) gap++;
      else break;
    end
    chk("pri_gap_len", 32'(gap), 32'(TB_GAP + 1));
    chk("pri_gnt3", 32'(gnt), 32'b1000);
    // End-run drops its request mid-frame but still completes.
    req = 4'b0101;
    wait_end("pri3", done, cyc);
    chk("pri_done3", 32'(done), 32'd1);

    // Reset during WAIT_TX of byte 3; pointer is 1 so requester 2 wins first.
    load_msg(10);
    wait_gnt("rst");
    chk("rst_pre_gnt", 32'(gnt), 32'b0100);
    wait_txq(3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_strobes", 32'({byte_ready, tx_start, frame_done, frame_err}), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_active_id", 32'(active_id), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    chk("post_rst_id", 32'(active_id), 32'd0);
    chk("post_rst_tx_data", 32'(tx_data), 32'd0);

    chk("idle_gap_strobe_viol", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_scheduler.md
MSG_SCHEDULER -- requirements
Module: msg_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 50000: max cycles to wait for a requester byte.
REQ-002 Parameter GAP_CYCLES, default 4340: idle cycles enforced after each frame.
REQ-003 Parameter MAX_LEN, default 16: max bytes per frame.
REQ-004 Parameter END_CHAR, default 8'h23 ('#'): frame terminator.
REQ-005 clk_50M  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  4  level request per requester; index 3 = end-run; 0..2 = fault/pickup/deposit formatters.
REQ-008 byte_valid  in  4  per-requester byte-available flag.
REQ-009 byte_data  in  32  per-requester byte; requester i on bits [8i+7:8i].
REQ-010 byte_ready  out  4  one-hot byte accept to the granted requester.
REQ-011 gnt  out  4  one-hot grant; held for the whole frame.
REQ-012 tx_data  out  8  byte to UART transmitter.
REQ-013 tx_start  out  1  single-cycle UART start pulse.
REQ-014 tx_busy  in  1  UART busy.
REQ-015 frame_done  out  1  single-cycle pulse: frame ended on END_CHAR.
REQ-016 frame_err  out  1  single-cycle pulse: frame aborted.
REQ-017 active_id  out  2  index of the current or last granted requester.

Function
REQ-018 States: IDLE, WAIT_BYTE, SEND, WAIT_TX, GAP.
REQ-019 IDLE: if any req bit is set, gnt and active_id load on the next edge, and the block enters WAIT_BYTE (1-cycle grant latency).
REQ-020 Arbitration: req[3] has strict priority; req[0..2] are served round-robin, with the pointer advancing to one past the last served index after each frame (done or error).
REQ-021 Requests are sampled only in IDLE; req changes during a frame have no effect; a granted requester that drops req still completes its frame.
REQ-022 WAIT_BYTE: byte_ready[active_id]=1 while tx_busy=0; on byte_valid&byte_ready, the byte is latched into tx_data and the block enters SEND.
REQ-023 SEND: tx_start=1 for exactly one cycle, then WAIT_TX.
REQ-024 WAIT_TX: ignore tx_busy in the first cycle; then wait for tx_busy=0.
REQ-025 After WAIT_TX: if the last byte == END_CHAR, pulse frame_done and enter GAP; else increment the byte count and return to WAIT_BYTE.
REQ-026 Byte count is 5 bits and resets at each grant; if the count reaches MAX_LEN without END_CHAR, pulse frame_err and enter GAP.
REQ-027 Timeout counter is 16 bits, cleared on entry to WAIT_BYTE; if it reaches TIMEOUT in WAIT_BYTE, pulse frame_err and enter GAP without sending.
REQ-028 GAP: gnt=0; count GAP_CYCLES, then enter IDLE; requests arriving during GAP wait.
REQ-029 byte_ready, tx_start, frame_done and frame_err are never asserted in IDLE or GAP.
REQ-030 tx_busy=1 in IDLE or GAP is ignored.

Reset
REQ-031 rst_n low clears immediately, including mid-frame: state=IDLE, gnt=0, byte_ready=0, tx_data=0, tx_start=0, frame_done=0, frame_err=0, active_id=0, RR pointer=0, all counters=0.
REQ-032 After rst_n rises, a request may be granted on the first clock edge.

Structure
REQ-033 Package msg_sched_pkg holds the state enum, END_CHAR default and requester index constants (REQ_FAULT=0, REQ_PICKUP=1, REQ_DEPOSIT=2, REQ_END=3).
REQ-034 The round-robin plus priority logic is one sub-module, msg_rr_arbiter (inputs req/pointer; output one-hot grant).

Verification
REQ-035 req=4'b0011 in IDLE: gnt=0001 one cycle later. After frame_done and GAP (req still 0011): gnt=0010.
REQ-036 req=4'b1111: gnt=1000 first. A later req[3] arriving mid-frame of requester 0 waits for that frame, then wins.
REQ-037 Requester 1 streams "BPM-SU-B2-#" with tx_busy high 10 cycles per byte: 11 tx_start pulses with correct tx_data order, then one frame_done, then gnt=0 for GAP_CYCLES.
REQ-038 Granted requester never asserts byte_valid: frame_err at TIMEOUT cycles after entering WAIT_BYTE, no tx_start, RR pointer advances.
REQ-039 17 bytes sent with no '#': frame_err after the 16th byte completes.
REQ-040 rst_n pulsed low during WAIT_TX of byte 3: all outputs 0 asynchronously; after release, a fresh grant to the lowest pending index with pointer=0.
